// File: rtl/sal_bank_pkg.sv
// Shared encodings for the per-bank DDR2 sequencer.
package sal_bank_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_ACTIVE      = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } state_e;

    // Two grants can never be closer than this: cmd_valid drops for one
    // cycle after every grant.
    localparam int MIN_SPACING = 2;

endpackage

// File: rtl/sal_tcnt.sv
// Loadable saturating down-counter. A value t loaded on the grant edge of
// cycle N reads as expired from cycle N+max(t,2)-1 onwards, which is the
// cycle in which the next command offer is registered, so that command is
// offered (and at the earliest granted) in cycle N+max(t,2).
module sal_tcnt
    import sal_bank_pkg::*;
#(
    parameter int T_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [T_W-1:0] value,
    output logic           expired
);

    localparam logic [T_W-1:0] SPACING = T_W'(MIN_SPACING);

    logic [T_W-1:0] count;
    logic [T_W-1:0] load_val;

    // Values below the minimum spacing behave like the minimum spacing.
    always_comb begin
        load_val = (value < SPACING) ? '0 : value - SPACING;
    end

    // Load on grant, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - T_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank DDR2 sequencer: tracks the open row, runs the bank FSM and holds
// back commands until the per-bank timing counters allow them.
//
// state          | meaning
// ST_IDLE        | bank closed, may offer REF or ACT
// ST_ACTIVATING  | ACT granted, waiting for tRCD
// ST_ACTIVE      | row open, may offer RD/WR or PRE
// ST_PRECHARGING | PRE granted, waiting for tRP
// ST_REFRESHING  | REF granted, waiting for tRFC
module sal_bank_ctrl
    import sal_bank_pkg::*;
#(
    parameter int ROW_W = 15,
    parameter int T_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [T_W-1:0]   t_rcd,
    input  logic [T_W-1:0]   t_rp,
    input  logic [T_W-1:0]   t_ras,
    input  logic [T_W-1:0]   t_rtp,
    input  logic [T_W-1:0]   t_wtp,
    input  logic [T_W-1:0]   t_rfc,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [ROW_W-1:0] req_row,
    output logic             req_ready,
    input  logic             ref_req,
    output logic             ref_ack,
    output logic             cmd_valid,
    output logic [2:0]       cmd,
    output logic [ROW_W-1:0] cmd_row,
    input  logic             cmd_grant,
    output logic             bank_open,
    output logic [ROW_W-1:0] open_row
);

    state_e           state, state_n, decide_state;
    cmd_e             cmd_q, cmd_n, offer_cmd;
    logic             cmd_valid_n, bank_open_n, ref_ack_n, offer;
    logic [ROW_W-1:0] cmd_row_n, open_row_n, offer_row;
    logic             ld_rcd, ld_ras, ld_rp, ld_rfc, ld_rtw2p;
    logic             rcd_exp, ras_exp, rp_exp, rfc_exp, rtw2p_exp;
    logic [T_W-1:0]   rtw2p_val;
    logic             grant;

    assign grant     = cmd_grant & cmd_valid;
    assign req_ready = grant & ((cmd_q == CMD_RD) | (cmd_q == CMD_WR));
    assign cmd       = cmd_q;
    assign rtw2p_val = (cmd_q == CMD_WR) ? t_wtp : t_rtp;

    sal_tcnt #(.T_W(T_W)) u_rcd (
        .clk(clk), .rst(rst), .load(ld_rcd), .value(t_rcd), .expired(rcd_exp)
    );
    sal_tcnt #(.T_W(T_W)) u_ras (
        .clk(clk), .rst(rst), .load(ld_ras), .value(t_ras), .expired(ras_exp)
    );
    sal_tcnt #(.T_W(T_W)) u_rp (
        .clk(clk), .rst(rst), .load(ld_rp), .value(t_rp), .expired(rp_exp)
    );
    sal_tcnt #(.T_W(T_W)) u_rfc (
        .clk(clk), .rst(rst), .load(ld_rfc), .value(t_rfc), .expired(rfc_exp)
    );
    sal_tcnt #(.T_W(T_W)) u_rtw2p (
        .clk(clk), .rst(rst), .load(ld_rtw2p), .value(rtw2p_val), .expired(rtw2p_exp)
    );

    // State and registered command/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_q     <= CMD_NOP;
            cmd_row   <= '0;
            open_row  <= '0;
            bank_open <= 1'b0;
            ref_ack   <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_valid <= cmd_valid_n;
            cmd_q     <= cmd_n;
            cmd_row   <= cmd_row_n;
            open_row  <= open_row_n;
            bank_open <= bank_open_n;
            ref_ack   <= ref_ack_n;
        end
    end

    // Next state, counter loads and the next command offer.
    // A pending offer is frozen until granted; new decisions are only taken
    // while nothing is offered. A timer expiring in ACTIVATING/PRECHARGING
    // moves the FSM on and makes the next decision in the same cycle so the
    // following command lands exactly on its earliest legal cycle.
    always_comb begin
        state_n      = state;
        decide_state = state;
        cmd_valid_n  = cmd_valid;
        cmd_n        = cmd_q;
        cmd_row_n    = cmd_row;
        open_row_n   = open_row;
        ref_ack_n    = 1'b0;
        ld_rcd       = 1'b0;
        ld_ras       = 1'b0;
        ld_rp        = 1'b0;
        ld_rfc       = 1'b0;
        ld_rtw2p     = 1'b0;
        offer        = 1'b0;
        offer_cmd    = CMD_NOP;
        offer_row    = open_row;

        if (grant) begin
            cmd_valid_n = 1'b0;
            cmd_n       = CMD_NOP;
            case (cmd_q)
                CMD_ACT: begin
                    state_n    = ST_ACTIVATING;
                    open_row_n = cmd_row;
                    ld_rcd     = 1'b1;
                    ld_ras     = 1'b1;
                end
                CMD_PRE: begin
                    state_n = ST_PRECHARGING;
                    ld_rp   = 1'b1;
                end
                CMD_REF: begin
                    state_n = ST_REFRESHING;
                    ld_rfc  = 1'b1;
                end
                CMD_RD, CMD_WR: ld_rtw2p = 1'b1;
                default: ;
            endcase
            cmd_row_n = open_row_n;
        end else if (!cmd_valid) begin
            case (state)
                ST_ACTIVATING: begin
                    if (rcd_exp) begin
                        state_n      = ST_ACTIVE;
                        decide_state = ST_ACTIVE;
                    end
                end
                ST_PRECHARGING: begin
                    if (rp_exp) begin
                        state_n      = ST_IDLE;
                        decide_state = ST_IDLE;
                    end
                end
                ST_REFRESHING: begin
                    if (rfc_exp) begin
                        state_n   = ST_IDLE;
                        ref_ack_n = 1'b1;
                    end
                end
                default: ;
            endcase

            case (decide_state)
                ST_IDLE: begin
                    // ref_req is still held during the ack cycle; ignore it then.
                    if (ref_req && !ref_ack) begin
                        offer     = 1'b1;
                        offer_cmd = CMD_REF;
                    end else if (req_valid) begin
                        offer     = 1'b1;
                        offer_cmd = CMD_ACT;
                        offer_row = req_row;
                    end
                end
                ST_ACTIVE: begin
                    if (ref_req || (req_valid && (req_row != open_row))) begin
                        if (ras_exp && rtw2p_exp) begin
                            offer     = 1'b1;
                            offer_cmd = CMD_PRE;
                        end
                    end else if (req_valid) begin
                        offer     = 1'b1;
                        offer_cmd = req_wr ? CMD_WR : CMD_RD;
                    end
                end
                default: ;
            endcase
        end

        if (offer) begin
            cmd_valid_n = 1'b1;
            cmd_n       = offer_cmd;
            cmd_row_n   = offer_row;
        end

        bank_open_n = (state_n == ST_ACTIVE);
    end

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Scoreboard bench for sal_bank_ctrl: an open-row model predicts the command
// stream, a monitor checks order, rows, timing bounds and handshake rules.
module tb_sal_bank_ctrl;

    localparam int ROW_W = 15;
    localparam int T_W   = 8;
    localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2,
                           C_WR = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [T_W-1:0]   t_rcd, t_rp, t_ras, t_rtp, t_wtp, t_rfc;
    logic             req_valid = 1'b0, req_wr = 1'b0;
    logic [ROW_W-1:0] req_row = '0;
    logic             req_ready;
    logic             ref_req = 1'b0;
    logic             ref_ack;
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [ROW_W-1:0] cmd_row;
    logic             cmd_grant;
    logic             bank_open;
    logic [ROW_W-1:0] open_row;

    sal_bank_ctrl #(.ROW_W(ROW_W), .T_W(T_W)) dut (
        .clk(clk), .rst(rst),
        .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rtp(t_rtp), .t_wtp(t_wtp),
        .t_rfc(t_rfc),
        .req_valid(req_valid), .req_wr(req_wr), .req_row(req_row), .req_ready(req_ready),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_row(cmd_row), .cmd_grant(cmd_grant),
        .bank_open(bank_open), .open_row(open_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       c;
        logic [ROW_W-1:0] row;
        bit               chk_row;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   grant_mode = 1;   // 0 withhold, 1 always, 2 random

    bit               m_open;
    logic [ROW_W-1:0] m_row;

    int act_c, rw_c, pre_c, ref_c, ack_c, any_c;
    bit rw_wr, ref_out;

    function automatic int sp(input logic [T_W-1:0] t);
        return (t < 2) ? 2 : int'(t);
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [ROW_W-1:0] row, input bit cr);
        exp_t e;
        e.c = c; e.row = row; e.chk_row = cr;
        sb_q.push_back(e);
    endtask

    // Open-page bank behaviour from the request point of view.
    task automatic model_req(input logic [ROW_W-1:0] row, input bit wr);
        if (!m_open) push(C_ACT, row, 1'b1);
        else if (m_row != row) begin
            push(C_PRE, m_row, 1'b1);
            push(C_ACT, row, 1'b1);
        end
        push(wr ? C_WR : C_RD, row, 1'b1);
        m_open = 1'b1;
        m_row  = row;
    endtask

    task automatic model_ref();
        if (m_open) push(C_PRE, m_row, 1'b1);
        push(C_REF, '0, 1'b0);
        m_open = 1'b0;
    endtask

    task automatic model_reset();
        m_open = 1'b0;
        m_row  = '0;
        sb_q.delete();
    endtask

    task automatic reset_trackers();
        act_c = -1000; rw_c = -1000; pre_c = -1000; ref_c = -1000;
        ack_c = -1000; any_c = -1000; rw_wr = 1'b0; ref_out = 1'b0;
    endtask

    initial begin
        cmd_grant = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (grant_mode)
                0:       cmd_grant = 1'b0;
                1:       cmd_grant = 1'b1;
                default: cmd_grant = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every accepted grant.
    initial begin
        exp_t             e;
        bit               prev_hold;
        logic [2:0]       prev_cmd;
        logic [ROW_W-1:0] prev_row;
        prev_hold = 1'b0;
        prev_cmd  = '0;
        prev_row  = '0;
        reset_trackers();
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                reset_trackers();
            end else begin
                if (prev_hold)
                    chk(cmd_valid === 1'b1 && cmd === prev_cmd && cmd_row === prev_row,
                        "offer_hold", {cmd_valid, cmd}, {1'b1, prev_cmd});
                if (cmd_valid && cmd_grant) begin
                    if (sb_q.size() == 0) begin
                        chk(1'b0, "unexpected_cmd", cmd, C_NOP);
                    end else begin
                        e = sb_q.pop_front();
                        chk(cmd === e.c, "cmd_order", cmd, e.c);
                        if (e.chk_row) chk(cmd_row === e.row, "cmd_row", cmd_row, e.row);
                        chk(req_ready === (e.c == C_RD || e.c == C_WR), "req_ready",
                            req_ready, (e.c == C_RD || e.c == C_WR));
                        if (e.c == C_RD || e.c == C_WR)
                            chk(open_row === e.row, "open_row", open_row, e.row);
                    end
                    chk(cyc - any_c >= 2, "spacing_min", cyc - any_c, 2);
                    case (cmd)
                        C_ACT: begin
                            chk(cyc - pre_c >= sp(t_rp), "trp_act", cyc - pre_c, sp(t_rp));
                            chk(cyc - ref_c >= sp(t_rfc), "trfc_act", cyc - ref_c, sp(t_rfc));
                            chk(bank_open === 1'b0, "bank_closed_act", bank_open, 0);
                            act_c = cyc;
                            rw_c  = -1000;
                        end
                        C_RD, C_WR: begin
                            chk(cyc - act_c >= sp(t_rcd), "trcd", cyc - act_c, sp(t_rcd));
                            chk(bank_open === 1'b1, "bank_open_rw", bank_open, 1);
                            rw_c  = cyc;
                            rw_wr = (cmd == C_WR);
                        end
                        C_PRE: begin
                            chk(cyc - act_c >= sp(t_ras), "tras", cyc - act_c, sp(t_ras));
                            chk(cyc - rw_c >= sp(rw_wr ? t_wtp : t_rtp), "trtp_twtp",
                                cyc - rw_c, sp(rw_wr ? t_wtp : t_rtp));
                            chk(bank_open === 1'b1, "bank_open_pre", bank_open, 1);
                            pre_c = cyc;
                        end
                        C_REF: begin
                            chk(cyc - pre_c >= sp(t_rp), "trp_ref", cyc - pre_c, sp(t_rp));
                            chk(cyc - ref_c >= sp(t_rfc), "trfc_ref", cyc - ref_c, sp(t_rfc));
                            chk(bank_open === 1'b0, "bank_closed_ref", bank_open, 0);
                            ref_c   = cyc;
                            ref_out = 1'b1;
                        end
                        default: chk(1'b0, "illegal_cmd", cmd, C_NOP);
                    endcase
                    any_c = cyc;
                end else if (cmd_grant) begin
                    chk(req_ready === 1'b0, "req_ready_ignored_grant", req_ready, 0);
                end
                if (ref_ack) begin
                    chk(ref_out, "ref_ack_spurious", ref_ack, 0);
                    chk(cyc == ref_c + sp(t_rfc), "ref_ack_time", cyc - ref_c, sp(t_rfc));
                    ack_c   = cyc;
                    ref_out = 1'b0;
                end
                prev_hold = cmd_valid && !cmd_grant;
                prev_cmd  = cmd;
                prev_row  = cmd_row;
            end
        end
    end

    task automatic do_req(input int row, input bit wr);
        int n;
        bit got;
        model_req(ROW_W'(row), wr);
        req_valid = 1'b1;
        req_wr    = wr;
        req_row   = ROW_W'(row);
        got = 1'b0;
        n   = 0;
        while (!got && n < 500) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            n++;
        end
        if (!got) chk(1'b0, "req_timeout", n, 500);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ack();
        int n;
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 500) begin
            @(negedge clk);
            if (ref_ack) got = 1'b1;
            n++;
        end
        if (!got) chk(1'b0, "ref_timeout", n, 500);
        @(posedge clk); #1;
        ref_req = 1'b0;
    endtask

    task automatic do_ref();
        model_ref();
        ref_req = 1'b1;
        wait_ack();
    endtask

    task automatic chk_zero(input string tag);
        chk(cmd_valid === 1'b0, {tag, "_cmd_valid"}, cmd_valid, 0);
        chk(cmd === C_NOP, {tag, "_cmd"}, cmd, 0);
        chk(cmd_row === '0, {tag, "_cmd_row"}, cmd_row, 0);
        chk(bank_open === 1'b0, {tag, "_bank_open"}, bank_open, 0);
        chk(open_row === '0, {tag, "_open_row"}, open_row, 0);
        chk(ref_ack === 1'b0, {tag, "_ref_ack"}, ref_ack, 0);
        chk(req_ready === 1'b0, {tag, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        int a0, w0, r0, n;
        bit got;
        t_rcd = 8'd3; t_ras = 8'd8; t_rp = 8'd3; t_rtp = 8'd2; t_wtp = 8'd6; t_rfc = 8'd20;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;

        // Row-closed read, then a row miss bounded by tRAS.
        do_req(5, 1'b0);
        chk(rw_c - act_c == 3, "rcd_delta", rw_c - act_c, 3);
        chk(bank_open === 1'b1 && open_row === 15'd5, "open_after_rd", open_row, 5);
        a0 = act_c;
        do_req(7, 1'b0);
        chk(pre_c - a0 == 8, "ras_bound_pre", pre_c - a0, 8);
        chk(act_c - pre_c == 3, "rp_delta", act_c - pre_c, 3);
        chk(rw_c - act_c == 3, "rcd_delta2", rw_c - act_c, 3);

        // Write followed by a miss: PRE held off by tWTP.
        do_req(7, 1'b1);
        w0 = rw_c;
        do_req(9, 1'b0);
        chk(pre_c - w0 == 6, "wtp_bound_pre", pre_c - w0, 6);

        // Refresh while a hit is waiting: PRE, REF, ack, then re-ACT.
        model_ref();
        model_req(15'd9, 1'b0);
        ref_req   = 1'b1;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_row   = 15'd9;
        wait_ack();
        chk(ack_c - ref_c == 20, "rfc_ack_delta", ack_c - ref_c, 20);
        got = 1'b0;
        n   = 0;
        while (!got && n < 500) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            n++;
        end
        if (!got) chk(1'b0, "req_timeout_ref", n, 500);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk(act_c > ack_c, "react_after_ack", act_c - ack_c, 1);

        // Grant withheld during an ACT offer; ref_req toggling is ignored.
        do_ref();
        grant_mode = 0;
        @(posedge clk); #1;
        model_req(15'd3, 1'b0);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_row   = 15'd3;
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ref_req = ~ref_req;
            @(negedge clk);
            chk(cmd_valid === 1'b1 && cmd === C_ACT && cmd_row === 15'd3,
                "withheld_act", {cmd_valid, cmd}, {1'b1, C_ACT});
        end
        @(posedge clk); #1;
        ref_req    = 1'b0;
        grant_mode = 1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 500) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            n++;
        end
        if (!got) chk(1'b0, "req_timeout_hold", n, 500);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Reset while ACTIVATING.
        do_ref();
        t_rcd = 8'd10;
        model_req(15'd4, 1'b0);
        req_valid = 1'b1;
        req_row   = 15'd4;
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (cmd_valid && cmd_grant && cmd == C_ACT) got = 1'b1;
            n++;
        end
        if (!got) chk(1'b0, "act_timeout", n, 100);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk); #1;

        // Timing values below 2 behave as 2.
        t_rcd = 8'd0; t_ras = 8'd1; t_rp = 8'd0; t_rtp = 8'd1;
        do_req(6, 1'b0);
        chk(rw_c - act_c == 2, "rcd_clamp", rw_c - act_c, 2);
        r0 = rw_c;
        do_req(2, 1'b0);
        chk(pre_c - r0 == 2, "rtp_clamp", pre_c - r0, 2);
        chk(act_c - pre_c == 2, "rp_clamp", act_c - pre_c, 2);
        chk(rw_c - act_c == 2, "rcd_clamp2", rw_c - act_c, 2);

        // Randomized traffic against the model with random grants.
        rst = 1'b1;
        model_reset();
        t_rcd = 8'($urandom_range(0, 7));
        t_ras = 8'($urandom_range(0, 12));
        t_rp  = 8'($urandom_range(0, 7));
        t_rtp = 8'($urandom_range(0, 7));
        t_wtp = 8'($urandom_range(0, 9));
        t_rfc = 8'($urandom_range(0, 15));
        grant_mode = 2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) do_ref();
            else do_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        chk(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
